pipelined_cla_adder: RTL and testbench
======================================

PIPELINED_CLA_ADDER -- requirements
Module: pipelined_cla_adder

Interface
REQ-001 SHALL expose parameter WIDTH, default 32, operand/sum width in bits.
REQ-002 SHALL expose parameter SLICES_PER_STAGE, default 1, number of 4-bit CLA slices evaluated per pipeline stage.
REQ-003 SHALL use one clock; reset is asynchronous and active-low.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 in_valid  input  1  operands present.
REQ-007 in_ready  output  1  block accepts operands this cycle.
REQ-008 a, b  input  WIDTH  operands.
REQ-009 cin  input  1  carry-in.
REQ-010 sub  input  1  0 = a+b+cin, 1 = a+~b+cin.
REQ-011 out_valid  output  1  result present.
REQ-012 out_ready  input  1  consumer accepts result.
REQ-013 sum  output  WIDTH  result.
REQ-014 cout  output  1  carry out of MSB.
REQ-015 ovf  output  1  signed overflow (carry into MSB XOR cout).

Function
REQ-016 Pipeline depth SHALL be L = WIDTH/(4*SLICES_PER_STAGE); stage k SHALL compute slices k*SLICES_PER_STAGE .. (k+1)*SLICES_PER_STAGE-1.
REQ-017 Elaboration SHALL fail if WIDTH < 4 or WIDTH mod (4*SLICES_PER_STAGE) != 0.
REQ-018 Within a stage, slices SHALL ripple the carry combinationally; between stages the carry SHALL be registered.
REQ-019 Unprocessed operand bits SHALL be carried forward in skew registers; completed sum bits SHALL be carried forward in de-skew registers, so one transaction occupies one stage per cycle.
REQ-020 Operand b SHALL be inverted at acceptance when sub=1; cin SHALL be used unmodified (subtract a-b requires sub=1, cin=1).
REQ-021 Transfer on input SHALL occur at a rising edge with in_valid && in_ready; transfer on output at a rising edge with out_valid && out_ready.
REQ-022 Advance enable adv = !out_valid || out_ready; in_ready SHALL equal adv; all stage registers, including per-stage valid bits, SHALL load only when adv=1.
REQ-023 When adv=1 and in_valid=0, a bubble (valid=0) SHALL enter stage 0; bubbles are not squeezed.
REQ-024 Unstalled latency SHALL be exactly L cycles: accepted at edge t, out_valid=1 with the result after edge t+L-1; each stalled cycle adds one cycle.
REQ-025 Simultaneous output transfer and input acceptance with a full pipeline SHALL both occur in the same edge, giving throughput 1 result/cycle.
REQ-026 sum, cout, ovf SHALL be stable while out_valid=1 and out_ready=0.
REQ-027 Results SHALL leave in acceptance order; no transaction SHALL be dropped or duplicated.
REQ-028 Arithmetic SHALL be modulo 2^WIDTH; cout and ovf SHALL be computed from the full WIDTH-bit carry chain.

Reset
REQ-029 On rst_n=0 all valid bits, sum, cout, ovf and all skew/carry registers SHALL clear to 0 immediately, independent of clk.
REQ-030 After reset out_valid=0, hence in_ready=1.
REQ-031 Reset mid-operation SHALL discard all in-flight transactions; none SHALL appear after reset release.

Structure
REQ-032 A shared package SHALL hold CLA_SLICE_W = 4 and the sub-mode encodings OP_ADD = 0, OP_SUB = 1.
REQ-033 One sub-module cla4_slice (4-bit carry-lookahead slice: a, b, cin -> s, p, g, cout) SHALL be instantiated WIDTH/4 times via generate.
REQ-034 Stage registers, skew buffers and handshake logic SHALL reside in pipelined_cla_adder.

Verification (WIDTH=32, SLICES_PER_STAGE=1, L=8 unless stated)
REQ-035 a=FFFFFFFF, b=00000001, cin=0, sub=0, out_ready=1 -> 8 cycles later sum=00000000, cout=1, ovf=0.
REQ-036 a=00000005, b=00000007, cin=1, sub=1 -> sum=FFFFFFFE, cout=0, ovf=0; a=7FFFFFFF, b=00000001, cin=0, sub=0 -> sum=80000000, ovf=1.
REQ-037 20 back-to-back random transactions, out_ready=1 -> first out_valid 8 cycles after first acceptance, then 20 consecutive results matching the reference model, in order.
REQ-038 Same stream with out_ready=0 for 3 cycles mid-stream -> in_ready=0 during those cycles, outputs held stable, no loss or reordering.
REQ-039 rst_n pulsed low with 5 transactions in flight -> out_valid=0 immediately, no stale result after release, next accepted transaction correct after 8 cycles.
REQ-040 Repeat REQ-035 and REQ-037 with WIDTH=64, SLICES_PER_STAGE=4 (L=4) -> latency 4, results correct.

Source files
------------

// File: rtl/pipelined_cla_adder_pkg.sv
// Shared constants for the pipelined carry-lookahead adder: slice width and
// the encoding of the sub (add/subtract) select.
package pipelined_cla_adder_pkg;

   localparam int unsigned CLA_SLICE_W = 4;

   localparam logic OP_ADD = 1'b0;
   localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/cla4_slice.sv
// 4-bit carry-lookahead slice: sum bits plus group propagate/generate and
// carry-out, all resolved from the slice carry-in without internal ripple.
module cla4_slice
   import pipelined_cla_adder_pkg::*;
(
   input  logic [CLA_SLICE_W-1:0] a_i,
   input  logic [CLA_SLICE_W-1:0] b_i,
   input  logic                   cin_i,
   output logic [CLA_SLICE_W-1:0] s_o,
   output logic                   p_o,
   output logic                   g_o,
   output logic                   cout_o
);

   logic [CLA_SLICE_W-1:0] p;
   logic [CLA_SLICE_W-1:0] g;
   logic [CLA_SLICE_W-1:0] c;

   assign p = a_i ^ b_i;
   assign g = a_i & b_i;

   always_comb begin
      c    = '0;
      c[0] = cin_i;
      c[1] = g[0] | (p[0] & cin_i);
      c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin_i);
      c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin_i);
   end

   assign p_o    = &p;
   assign g_o    = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
   assign cout_o = g_o | (p_o & cin_i);
   assign s_o    = p ^ c;

endmodule

// File: rtl/pipelined_cla_adder.sv
// Pipelined adder/subtractor: each stage resolves SLICES_PER_STAGE 4-bit CLA
// slices and registers its carry; operand and finished sum bits travel alongside.
module pipelined_cla_adder
   import pipelined_cla_adder_pkg::*;
#(
   parameter int unsigned WIDTH            = 32,
   parameter int unsigned SLICES_PER_STAGE = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int unsigned StageW  = CLA_SLICE_W * SLICES_PER_STAGE;
   localparam int unsigned Depth   = WIDTH / StageW;
   localparam int unsigned NSlices = WIDTH / CLA_SLICE_W;

   if (SLICES_PER_STAGE == 0 || WIDTH < CLA_SLICE_W || (WIDTH % StageW) != 0) begin : g_param_check
      $error("pipelined_cla_adder: WIDTH must be >= 4 and a multiple of 4*SLICES_PER_STAGE");
   end

   logic             adv;
   logic [WIDTH-1:0] a_q  [Depth];
   logic [WIDTH-1:0] b_q  [Depth];
   logic [WIDTH-1:0] s_q  [Depth];
   logic [Depth-1:0] c_q;
   logic [Depth-1:0] v_q;
   logic             ovf_q;

   logic [WIDTH-1:0]   a_in [Depth];
   logic [WIDTH-1:0]   b_in [Depth];
   logic [WIDTH-1:0]   s_in [Depth];
   logic [WIDTH-1:0]   s_d  [Depth];
   logic [Depth-1:0]   c_in;
   logic [Depth-1:0]   c_d;
   logic [WIDTH-1:0]   s_all;
   logic [NSlices-1:0] p_all;
   logic [NSlices-1:0] g_all;
   logic               ovf_d;
   logic               unused_pg;

   assign adv      = !v_q[Depth-1] || out_ready;
   assign in_ready = adv;

   // Stage k works on the operands held by rank k-1; stage 0 works on the ports.
   always_comb begin
      a_in[0] = a;
      b_in[0] = (sub == OP_SUB) ? ~b : b;
      s_in[0] = '0;
      c_in[0] = cin;
      for (int k = 1; k < Depth; k++) begin
         a_in[k] = a_q[k-1];
         b_in[k] = b_q[k-1];
         s_in[k] = s_q[k-1];
         c_in[k] = c_q[k-1];
      end
   end

   for (genvar i = 0; i < NSlices; i++) begin : g_slice
      localparam int unsigned Stage = i / SLICES_PER_STAGE;
      logic cin_s;
      logic cout_s;
      if ((i % SLICES_PER_STAGE) == 0) begin : g_head
         assign cin_s = c_in[Stage];
      end else begin : g_chain
         assign cin_s = g_slice[i-1].cout_s;
      end
      cla4_slice u_slice (
         .a_i    (a_in[Stage][i*CLA_SLICE_W +: CLA_SLICE_W]),
         .b_i    (b_in[Stage][i*CLA_SLICE_W +: CLA_SLICE_W]),
         .cin_i  (cin_s),
         .s_o    (s_all[i*CLA_SLICE_W +: CLA_SLICE_W]),
         .p_o    (p_all[i]),
         .g_o    (g_all[i]),
         .cout_o (cout_s)
      );
   end

   for (genvar k = 0; k < Depth; k++) begin : g_stage_carry
      assign c_d[k] = g_slice[(k+1)*SLICES_PER_STAGE-1].cout_s;
   end

   // Group propagate/generate are not needed once slices ripple inside a stage.
   assign unused_pg = ^{p_all, g_all};

   always_comb begin
      for (int k = 0; k < Depth; k++) begin
         s_d[k]                      = s_in[k];
         s_d[k][k*StageW +: StageW] = s_all[k*StageW +: StageW];
      end
   end

   // Carry into the MSB recovered from its sum bit: s = a ^ b ^ c.
   assign ovf_d = (a_in[Depth-1][WIDTH-1] ^ b_in[Depth-1][WIDTH-1] ^ s_all[WIDTH-1]) ^ c_d[Depth-1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < Depth; k++) begin
            a_q[k] <= '0;
            b_q[k] <= '0;
            s_q[k] <= '0;
         end
         c_q   <= '0;
         v_q   <= '0;
         ovf_q <= 1'b0;
      end else if (adv) begin
         for (int k = 0; k < Depth; k++) begin
            a_q[k] <= a_in[k];
            b_q[k] <= b_in[k];
            s_q[k] <= s_d[k];
         end
         v_q[0] <= in_valid;
         for (int k = 1; k < Depth; k++) begin
            v_q[k] <= v_q[k-1];
         end
         c_q   <= c_d;
         ovf_q <= ovf_d;
      end
   end

   assign out_valid = v_q[Depth-1];
   assign sum       = s_q[Depth-1];
   assign cout      = c_q[Depth-1];
   assign ovf       = ovf_q;

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Scoreboard bench for pipelined_cla_adder: a 32-bit/L=8 and a 64-bit/L=4 instance,
// expected results from plain wide arithmetic, checked by an independent monitor.
module tb_pipelined_cla_adder;

   localparam int unsigned L32 = 8;
   localparam int unsigned L64 = 4;

   typedef struct {
      logic [63:0] sum;
      logic        cout;
      logic        ovf;
      longint      acc;
      bit          lat;
   } exp_t;

   logic        clk;
   logic        rst_n;
   logic        ordy;
   logic        iv32, rdy32, ci32, su32, ov32, co32, of32;
   logic [31:0] a32, b32, s32;
   logic        iv64, rdy64, ci64, su64, ov64, co64, of64;
   logic [63:0] a64, b64, s64;

   exp_t   q32[$];
   exp_t   q64[$];
   int     n_cmp = 0;
   int     n_bad = 0;
   longint cyc = 0;

   pipelined_cla_adder #(.WIDTH(32), .SLICES_PER_STAGE(1)) u_dut32 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv32), .in_ready(rdy32), .a(a32), .b(b32),
      .cin(ci32), .sub(su32), .out_valid(ov32), .out_ready(ordy), .sum(s32),
      .cout(co32), .ovf(of32)
   );

   pipelined_cla_adder #(.WIDTH(64), .SLICES_PER_STAGE(4)) u_dut64 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv64), .in_ready(rdy64), .a(a64), .b(b64),
      .cin(ci64), .sub(su64), .out_valid(ov64), .out_ready(ordy), .sum(s64),
      .cout(co64), .ovf(of64)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog expired");
   end

   // Reference: modulo-2^w sum, carry out of bit w-1, two's-complement overflow rule.
   function automatic exp_t model(input int w, input logic [63:0] a, input logic [63:0] b,
                                  input logic ci, input logic su);
      exp_t        r;
      logic [63:0] mask, aa, bb;
      logic [64:0] t;
      mask   = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'h1 << w) - 64'h1);
      aa     = a & mask;
      bb     = (su ? ~b : b) & mask;
      t      = {1'b0, aa} + {1'b0, bb} + {64'h0, ci};
      r.sum  = t[63:0] & mask;
      r.cout = t[w];
      r.ovf  = (aa[w-1] == bb[w-1]) && (r.sum[w-1] != aa[w-1]);
      r.acc  = 0;
      r.lat  = 1'b0;
      return r;
   endfunction

   task automatic cmp(input string nm, input logic [63:0] got, input logic [63:0] want);
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", nm, got, want);
      end
   endtask

   task automatic check_out(input bit w64, input logic [63:0] s, input logic co, input logic of,
                            input logic rdy);
      exp_t  e;
      string t;
      int    lat;
      int    sz;
      t   = w64 ? "w64" : "w32";
      lat = w64 ? L64 - 1 : L32 - 1;
      sz  = w64 ? q64.size() : q32.size();
      if (sz == 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL %s stray result: sum=%0h appeared with nothing outstanding", t, s);
         return;
      end
      e = w64 ? q64[0] : q32[0];
      cmp({t, " sum"}, s, e.sum);
      cmp({t, " cout"}, {63'h0, co}, {63'h0, e.cout});
      cmp({t, " ovf"}, {63'h0, of}, {63'h0, e.ovf});
      if (ordy) begin
         if (w64) void'(q64.pop_front());
         else void'(q32.pop_front());
         if (e.lat) cmp({t, " latency"}, cyc - e.acc, 64'(lat));
      end else begin
         cmp({t, " in_ready during stall"}, {63'h0, rdy}, 64'h0);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         if (ov32) check_out(1'b0, {32'h0, s32}, co32, of32, rdy32);
         if (ov64) check_out(1'b1, s64, co64, of64, rdy64);
      end
   end

   task automatic send(input bit w64, input logic [63:0] a, input logic [63:0] b,
                       input logic ci, input logic su, input bit lat);
      exp_t e;
      bit   ok;
      ok = 1'b0;
      if (w64) begin
         iv64 = 1'b1; a64 = a; b64 = b; ci64 = ci; su64 = su;
      end else begin
         iv32 = 1'b1; a32 = a[31:0]; b32 = b[31:0]; ci32 = ci; su32 = su;
      end
      for (int n = 0; n < 200 && !ok; n++) begin
         @(negedge clk);
         ok = w64 ? rdy64 : rdy32;
         @(posedge clk);
         #1;
      end
      if (!ok) begin
         n_cmp++;
         n_bad++;
         $display("FAIL %s accept: in_ready never rose, got 0, expected 1", w64 ? "w64" : "w32");
      end else begin
         e     = model(w64 ? 64 : 32, a, b, ci, su);
         e.acc = cyc;
         e.lat = lat;
         if (w64) q64.push_back(e);
         else q32.push_back(e);
      end
   endtask

   task automatic idle();
      iv32 = 1'b0;
      iv64 = 1'b0;
   endtask

   task automatic drain(input bit w64);
      int left;
      left = w64 ? q64.size() : q32.size();
      for (int n = 0; n < 100 && left != 0; n++) begin
         @(posedge clk);
         #1;
         left = w64 ? q64.size() : q32.size();
      end
      cmp(w64 ? "w64 drain outstanding" : "w32 drain outstanding", 64'(left), 64'h0);
   endtask

   initial begin
      rst_n = 1'b1; ordy = 1'b1;
      iv32 = 1'b0; a32 = '0; b32 = '0; ci32 = 1'b0; su32 = 1'b0;
      iv64 = 1'b0; a64 = '0; b64 = '0; ci64 = 1'b0; su64 = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      cmp("w32 reset out_valid", {63'h0, ov32}, 64'h0);
      cmp("w32 reset in_ready", {63'h0, rdy32}, 64'h1);
      cmp("w32 reset sum", {32'h0, s32}, 64'h0);
      cmp("w32 reset cout/ovf", {62'h0, co32, of32}, 64'h0);
      cmp("w64 reset out_valid", {63'h0, ov64}, 64'h0);
      cmp("w64 reset in_ready", {63'h0, rdy64}, 64'h1);
      #19 rst_n = 1'b1;
      @(posedge clk);
      #1;

      send(1'b0, 64'hFFFF_FFFF, 64'h1, 1'b0, 1'b0, 1'b1);
      idle(); drain(1'b0);
      send(1'b0, 64'h5, 64'h7, 1'b1, 1'b1, 1'b1);
      idle(); drain(1'b0);
      send(1'b0, 64'h7FFF_FFFF, 64'h1, 1'b0, 1'b0, 1'b1);
      idle(); drain(1'b0);
      send(1'b0, 64'h8000_0000, 64'h1, 1'b1, 1'b1, 1'b1);
      idle(); drain(1'b0);

      for (int i = 0; i < 20; i++) begin
         send(1'b0, {32'h0, $urandom}, {32'h0, $urandom}, 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), 1'b1);
      end
      idle(); drain(1'b0);

      fork
         for (int i = 0; i < 20; i++) begin
            send(1'b0, {32'h0, $urandom}, {32'h0, $urandom}, 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 1'b0);
         end
         begin
            repeat (12) @(posedge clk);
            #1 ordy = 1'b0;
            repeat (3) @(posedge clk);
            #1 ordy = 1'b1;
         end
      join
      idle(); drain(1'b0);

      for (int i = 0; i < 5; i++) begin
         send(1'b0, {32'h0, $urandom}, {32'h0, $urandom}, 1'b0, 1'b0, 1'b0);
      end
      idle();
      repeat (3) @(posedge clk);
      #3;
      cmp("w32 pre-reset out_valid", {63'h0, ov32}, 64'h1);
      rst_n = 1'b0;
      #1;
      cmp("w32 async reset out_valid", {63'h0, ov32}, 64'h0);
      cmp("w32 async reset sum", {32'h0, s32}, 64'h0);
      cmp("w32 async reset in_ready", {63'h0, rdy32}, 64'h1);
      q32.delete();
      #2 rst_n = 1'b1;
      repeat (12) @(posedge clk);
      #1;
      cmp("w32 post-reset out_valid", {63'h0, ov32}, 64'h0);
      send(1'b0, 64'h1234_5678, 64'h0FED_CBA9, 1'b1, 1'b0, 1'b1);
      idle(); drain(1'b0);

      send(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 1'b1);
      idle(); drain(1'b1);
      send(1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 1'b1);
      idle(); drain(1'b1);
      for (int i = 0; i < 20; i++) begin
         send(1'b1, {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), 1'b1);
      end
      idle(); drain(1'b1);

      repeat (2) @(posedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
